pattern_history_table: RTL and testbench
========================================

# pattern_history_table

Gshare-style pattern history table that consumes branch history and emits taken/not-taken predictions. It holds 2^INDEX_BITS two-bit saturating counters indexed by PC xor global history. It trains the counters on branch resolution and drives the shift-enable/shift-bit pair that feeds the branch history register. It sits between fetch (predict port), execute/resolve (update port) and the history register (history port).

## Interface
- HISTSIZE, 2, width of global history; must be ≤ INDEX_BITS
- INDEX_BITS, 6, log2 of counter count (64 entries)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pred_valid  in  1  prediction request
- pred_pc  in  32  PC of branch to predict
- pred_hist  in  HISTSIZE  current global history (history register output)
- pred_ready  out  1  table initialised, requests accepted
- pred_out_valid  out  1  prediction result valid
- pred_taken  out  1  predicted direction
- upd_valid  in  1  resolved branch update
- upd_pc  in  32  PC of resolved branch
- upd_hist  in  HISTSIZE  history snapshot used when that branch was predicted
- upd_taken  in  1  actual outcome
- hist_en  out  1  shift enable toward history register
- hist_bit  out  1  outcome bit shifted into history register

## Operation
- Index = pc[INDEX_BITS+1:2] xor {zero-extend, hist}; the history occupies the low bits of the index.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter MSB.
- FSM states:
  - INIT: entered on rst. An index counter sweeps 0 to 2^INDEX_BITS-1, writing 01 to one entry per cycle. pred_ready=0. Predict and update requests are ignored, with no pred_out_valid and no hist_en. After the last entry is written, go to RUN.
  - RUN: pred_ready=1. Predict and update are serviced every cycle, independently.
- Update (RUN): counter at upd index +1 if upd_taken, -1 otherwise. The counter saturates at 11 and 00 with no wrap.
- Simultaneous predict and update to the same index in one cycle: the prediction returns the pre-update counter value. The update commits at that edge.
- History port: hist_en and hist_bit are registered copies of upd_valid and upd_taken. They are generated only in RUN. No other source drives them.
- Reset in any state, including mid-sweep or mid-run: return to INIT, restart the sweep at index 0, and clear all outputs. Previously trained counters are overwritten by the sweep.

## Timing
- Reset values:
  - pred_ready=0, pred_out_valid=0, pred_taken=0, hist_en=0, hist_bit=0.
  - FSM=INIT, sweep index=0.
- Init latency: the first cycle after rst deassert writes entry 0. pred_ready rises exactly 2^INDEX_BITS cycles after rst deassert (64 by default).
- Predict latency: 1 cycle. pred_valid sampled at edge N gives pred_out_valid=1 and pred_taken valid after edge N, for one cycle. Back-to-back requests give back-to-back results.
- Update latency: the counter is written at the edge sampling upd_valid. A predict in the following cycle sees the new value. hist_en pulses for one cycle after that same edge.
- No stalls or backpressure in RUN. One predict and one update per cycle.

## Test plan
- Init sweep: assert rst 2 cycles, release. Check pred_ready=0 for 64 cycles, then 1. Predict pc=0x100, hist=00: pred_out_valid=1 next cycle, pred_taken=0.
- Saturation: update pc=0x100, hist=00, taken ×3. Predict gives taken=1 (counter 11). Two not-taken updates give counter 01, predict gives taken=0. Four further not-taken updates keep the counter at 00, and one taken update then still predicts 0.
- Xor aliasing: train pc=0x104, hist=01 taken ×2. Predict pc=0x100, hist=00 gives 1 (same index 0). Predict pc=0x104, hist=00 (index 1) gives 0.
- Same-cycle collision: with the counter at 01 for index 0, issue predict and taken update to index 0 in one cycle. Result is taken=0. A predict the next cycle gives taken=1.
- History port: in RUN, upd_valid=1 with upd_taken=1 gives hist_en=1 and hist_bit=1 for exactly one cycle. upd_valid pulses during INIT never raise hist_en.
- Mid-run reset: train index 0 to 11, assert rst 1 cycle. pred_ready=0 for 64 cycles and outputs return to 0. Predict pc=0x100, hist=00 then gives 0.

Source files
------------

// File: rtl/pattern_history_table.sv
// pattern_history_table
//   Gshare-style pattern history table. Holds 2^INDEX_BITS two-bit saturating
//   counters indexed by pc[INDEX_BITS+1:2] xor zero-extended global history.
//   After reset the table is swept to weak-not-taken (01), one entry per cycle,
//   before requests are accepted.
//
// Parameters
//   HISTSIZE    width of global history (must be <= INDEX_BITS)
//   INDEX_BITS  log2 of counter count
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   pred_valid/pc/hist  prediction request (fetch side)
//   pred_ready       table initialised, requests accepted
//   pred_out_valid   prediction result valid (1 cycle after request)
//   pred_taken       predicted direction (counter MSB)
//   upd_valid/pc/hist/taken  resolved branch update (execute side)
//   hist_en, hist_bit  registered shift-enable / shift-bit for the history register

module pattern_history_table #(
   parameter int HISTSIZE   = 2,
   parameter int INDEX_BITS = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pred_valid,
   input  logic [31:0]         pred_pc,
   input  logic [HISTSIZE-1:0] pred_hist,
   output logic                pred_ready,
   output logic                pred_out_valid,
   output logic                pred_taken,
   input  logic                upd_valid,
   input  logic [31:0]         upd_pc,
   input  logic [HISTSIZE-1:0] upd_hist,
   input  logic                upd_taken,
   output logic                hist_en,
   output logic                hist_bit
);

   localparam int ENTRIES = 2 ** INDEX_BITS;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                  state;
   state_t                  next_state;
   logic                    run;
   logic [INDEX_BITS-1:0]   sweep_idx;
   logic [1:0]              counters [ENTRIES];
   logic [INDEX_BITS-1:0]   pred_idx;
   logic [INDEX_BITS-1:0]   upd_idx;
   logic [1:0]              upd_cnt;

   // PC bits outside the index window do not contribute to the hash
   logic                    unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                             upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

   // Index hashing: history sits in the low bits of the index
   always_comb begin
      pred_idx = pred_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(pred_hist);
      upd_idx  = upd_pc[INDEX_BITS+1:2]  ^ INDEX_BITS'(upd_hist);
      upd_cnt  = counters[upd_idx];
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_INIT;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         ST_INIT: if (sweep_idx == '1) next_state = ST_RUN;
         ST_RUN:  next_state = ST_RUN;
         default: next_state = ST_INIT;
      endcase
   end

   // Output logic
   always_comb begin
      run        = (state == ST_RUN);
      pred_ready = run;
   end

   // Sweep index: advances only while initialising, restarts at 0 on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sweep_idx <= '0;
      end else if (state == ST_INIT) begin
         sweep_idx <= sweep_idx + 1'b1;
      end
   end

   // Counter array: no reset term, the sweep provides the initial contents
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_INIT) begin
            counters[sweep_idx] <= 2'b01;
         end else if (upd_valid) begin
            if (upd_taken && (upd_cnt != 2'b11)) begin
               counters[upd_idx] <= upd_cnt + 2'b01;
            end else if (!upd_taken && (upd_cnt != 2'b00)) begin
               counters[upd_idx] <= upd_cnt - 2'b01;
            end
         end
      end
   end

   // Prediction and history outputs; the array read sees the pre-update
   // value when predict and update hit the same entry in one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_out_valid <= 1'b0;
         pred_taken     <= 1'b0;
         hist_en        <= 1'b0;
         hist_bit       <= 1'b0;
      end else begin
         pred_out_valid <= run && pred_valid;
         pred_taken     <= run && pred_valid && counters[pred_idx][1];
         hist_en        <= run && upd_valid;
         hist_bit       <= run && upd_valid && upd_taken;
      end
   end

endmodule

// File: tb/tb_pattern_history_table.sv
// Testbench for pattern_history_table: directed sequences with literal
// expectations plus a behavioural table model checked every cycle.

module tb_pattern_history_table;

   localparam int HB      = 2;
   localparam int IB      = 6;
   localparam int ENTRIES = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          pred_valid;
   logic [31:0]   pred_pc;
   logic [HB-1:0] pred_hist;
   logic          pred_ready;
   logic          pred_out_valid;
   logic          pred_taken;
   logic          upd_valid;
   logic [31:0]   upd_pc;
   logic [HB-1:0] upd_hist;
   logic          upd_taken;
   logic          hist_en;
   logic          hist_bit;

   int compared   = 0;
   int mismatched = 0;

   pattern_history_table #(.HISTSIZE(HB), .INDEX_BITS(IB)) dut (
      .clk            (clk),
      .rst            (rst),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .pred_hist      (pred_hist),
      .pred_ready     (pred_ready),
      .pred_out_valid (pred_out_valid),
      .pred_taken     (pred_taken),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_hist       (upd_hist),
      .upd_taken      (upd_taken),
      .hist_en        (hist_en),
      .hist_bit       (hist_bit)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int   m_cnt [ENTRIES];
   bit   m_live  = 0;
   bit   m_ready = 0;
   int   m_cycles = 0;
   bit   e_pov, e_pt, e_he, e_hb;

   function automatic int hash(input logic [31:0] pc, input logic [HB-1:0] h);
      return ((int'(pc) >>> 2) ^ int'(h)) % ENTRIES;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_live = 1; m_ready = 0; m_cycles = 0;
         e_pov = 0; e_pt = 0; e_he = 0; e_hb = 0;
      end else if (m_live && !m_ready) begin
         e_pov = 0; e_pt = 0; e_he = 0; e_hb = 0;
         m_cycles++;
         if (m_cycles == ENTRIES) begin
            m_ready = 1;
            for (int i = 0; i < ENTRIES; i++) m_cnt[i] = 1;
         end
      end else if (m_live) begin
         e_pov = pred_valid;
         e_pt  = pred_valid && (m_cnt[hash(pred_pc, pred_hist)] >= 2);
         e_he  = upd_valid;
         e_hb  = upd_valid && upd_taken;
         if (upd_valid) begin
            int k;
            k = hash(upd_pc, upd_hist);
            if (upd_taken) m_cnt[k] = (m_cnt[k] == 3) ? 3 : m_cnt[k] + 1;
            else           m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
         end
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (m_live) begin
         check("model_ready", pred_ready, m_ready);
         check("model_pov", pred_out_valid, e_pov);
         if (e_pov) check("model_taken", pred_taken, e_pt);
         check("model_hist_en", hist_en, e_he);
         if (e_he) check("model_hist_bit", hist_bit, e_hb);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic predict(input logic [31:0] pc, input logic [HB-1:0] h,
                          input logic exp, input string name);
      pred_valid = 1; pred_pc = pc; pred_hist = h;
      tick;
      pred_valid = 0;
      check({name, "_valid"}, pred_out_valid, 1'b1);
      check(name, pred_taken, exp);
   endtask

   task automatic update(input logic [31:0] pc, input logic [HB-1:0] h, input logic t);
      upd_valid = 1; upd_pc = pc; upd_hist = h; upd_taken = t;
      tick;
      upd_valid = 0;
   endtask

   task automatic init_sweep(input bool_poke);
      for (int i = 1; i <= ENTRIES; i++) begin
         // requests during the sweep must be ignored
         upd_valid  = bool_poke && (i >= 10 && i <= 12);
         upd_taken  = 1;
         upd_pc     = 32'h100;
         upd_hist   = '0;
         pred_valid = bool_poke && (i == 20);
         pred_pc    = 32'h100;
         pred_hist  = '0;
         tick;
         check("init_ready", pred_ready, (i == ENTRIES));
         if (i < ENTRIES) begin
            check("init_hist_en", hist_en, 1'b0);
            check("init_pov", pred_out_valid, 1'b0);
         end
      end
      upd_valid = 0; pred_valid = 0;
   endtask

   initial begin
      rst = 1; pred_valid = 0; pred_pc = '0; pred_hist = '0;
      upd_valid = 0; upd_pc = '0; upd_hist = '0; upd_taken = 0;
      tick; tick;
      check("rst_ready", pred_ready, 1'b0);
      check("rst_pov", pred_out_valid, 1'b0);
      check("rst_hist_en", hist_en, 1'b0);
      rst = 0;
      init_sweep(1'b1);
      predict(32'h100, 2'b00, 1'b0, "init_pred");

      // saturation
      repeat (3) update(32'h100, 2'b00, 1'b1);
      predict(32'h100, 2'b00, 1'b1, "sat_strong_t");
      repeat (2) update(32'h100, 2'b00, 1'b0);
      predict(32'h100, 2'b00, 1'b0, "sat_weak_nt");
      repeat (4) update(32'h100, 2'b00, 1'b0);
      update(32'h100, 2'b00, 1'b1);
      predict(32'h100, 2'b00, 1'b0, "sat_floor");

      // xor aliasing: 0x104/01 shares index 0 with 0x100/00
      repeat (2) update(32'h104, 2'b01, 1'b1);
      predict(32'h100, 2'b00, 1'b1, "alias_idx0");
      predict(32'h104, 2'b00, 1'b0, "alias_idx1");

      // same-cycle collision: bring index 0 back to 01
      repeat (2) update(32'h100, 2'b00, 1'b0);
      pred_valid = 1; pred_pc = 32'h100; pred_hist = 2'b00;
      upd_valid = 1; upd_pc = 32'h100; upd_hist = 2'b00; upd_taken = 1;
      tick;
      pred_valid = 0; upd_valid = 0;
      check("collide_pre", pred_taken, 1'b0);
      predict(32'h100, 2'b00, 1'b1, "collide_post");

      // back-to-back predicts
      pred_valid = 1; pred_pc = 32'h100; pred_hist = 2'b00;
      tick;
      check("b2b_first", pred_out_valid, 1'b1);
      pred_pc = 32'h104;
      tick;
      pred_valid = 0;
      check("b2b_second_v", pred_out_valid, 1'b1);
      check("b2b_second", pred_taken, 1'b0);

      // history port
      update(32'h180, 2'b10, 1'b1);
      check("hist_en_pulse", hist_en, 1'b1);
      check("hist_bit_pulse", hist_bit, 1'b1);
      tick;
      check("hist_en_drop", hist_en, 1'b0);
      update(32'h180, 2'b10, 1'b0);
      check("hist_en_nt", hist_en, 1'b1);
      check("hist_bit_nt", hist_bit, 1'b0);

      // mixed traffic checked by the model
      for (int c = 0; c < 300; c++) begin
         pred_valid = ($urandom_range(0, 3) != 0);
         pred_pc    = 32'h100 + ($urandom_range(0, 7) << 2);
         pred_hist  = HB'($urandom_range(0, 3));
         upd_valid  = ($urandom_range(0, 2) != 0);
         upd_pc     = 32'h100 + ($urandom_range(0, 7) << 2);
         upd_hist   = HB'($urandom_range(0, 3));
         upd_taken  = ($urandom_range(0, 1) == 1);
         tick;
      end
      pred_valid = 0; upd_valid = 0;
      tick;

      // mid-run reset
      repeat (3) update(32'h100, 2'b00, 1'b1);
      predict(32'h100, 2'b00, 1'b1, "pre_reset_t");
      rst = 1;
      pred_valid = 1; upd_valid = 1; upd_taken = 1;
      tick;
      pred_valid = 0; upd_valid = 0;
      rst = 0;
      check("midrst_ready", pred_ready, 1'b0);
      check("midrst_pov", pred_out_valid, 1'b0);
      check("midrst_taken", pred_taken, 1'b0);
      check("midrst_hist_en", hist_en, 1'b0);
      check("midrst_hist_bit", hist_bit, 1'b0);
      init_sweep(1'b0);
      predict(32'h100, 2'b00, 1'b0, "post_reset_nt");
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
